// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the AC motor vector-drive datapath.
// Duty fields are sized for the widest supported carrier; narrower carriers zero-extend.
package ac_motor_pkg;

   localparam int SECTOR_W     = 3;
   localparam int DUTY_W       = 16;
   localparam int DEADTIME_DEF = 16;

   localparam logic [SECTOR_W-1:0] SEC_0 = 3'd0;
   localparam logic [SECTOR_W-1:0] SEC_1 = 3'd1;
   localparam logic [SECTOR_W-1:0] SEC_2 = 3'd2;
   localparam logic [SECTOR_W-1:0] SEC_3 = 3'd3;
   localparam logic [SECTOR_W-1:0] SEC_4 = 3'd4;
   localparam logic [SECTOR_W-1:0] SEC_5 = 3'd5;

   typedef enum logic {
      DIR_UP,
      DIR_DN
   } dir_e;

   typedef struct packed {
      logic [DUTY_W-1:0] u;
      logic [DUTY_W-1:0] v;
      logic [DUTY_W-1:0] w;
   } ac_motor_duty_t;

endpackage

// File: rtl/ac_motor_svpwm_if.sv
// Sector/vector-time command in, gate drives and valley strobe out.
interface ac_motor_svpwm_if
   import ac_motor_pkg::*;
#(
   parameter int WIDTH = 12
) ();

   logic                en;
   logic [SECTOR_W-1:0] sector;
   logic [WIDTH-1:0]    sine_pos;
   logic [WIDTH-1:0]    sine_neg;
   logic                u_h, u_l, v_h, v_l, w_h, w_l;
   logic                valley;

   modport master (
      output en, sector, sine_pos, sine_neg,
      input  u_h, u_l, v_h, v_l, w_h, w_l, valley
   );

   modport slave (
      input  en, sector, sine_pos, sine_neg,
      output u_h, u_l, v_h, v_l, w_h, w_l, valley
   );

endinterface

// File: rtl/ac_motor_deadtime.sv
// Per-phase dead-time inserter: a gate turns on only after the command has held
// its level long enough, and drops the cycle after the command leaves it.
module ac_motor_deadtime #(
   parameter int DEADTIME = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic cmd,
   output logic h,
   output logic l
);

   localparam logic [7:0] DT = 8'(DEADTIME);

   logic [7:0] cnt;
   logic       cmd_q;
   logic       settled;

   // cnt is the number of earlier cycles cmd has already spent at its present level
   assign settled = (cmd == cmd_q) && (cnt >= DT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         cmd_q <= 1'b0;
         h     <= 1'b0;
         l     <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         cmd_q <= 1'b0;
         h     <= 1'b0;
         l     <= 1'b0;
      end else begin
         cmd_q <= cmd;
         if (cmd != cmd_q)
            cnt <= 8'd1;
         else if (cnt < DT)
            cnt <= cnt + 8'd1;
         h <= cmd & settled;
         l <= ~cmd & settled;
      end
   end

endmodule

// File: rtl/ac_motor_svpwm.sv
// Centre-aligned space-vector PWM: up/down carrier, peak sampling of T1/T2,
// saturation and sector mux into shadow duties, valley handoff, dead-timed gates.
module ac_motor_svpwm
   import ac_motor_pkg::*;
#(
   parameter int WIDTH    = 12,
   parameter int DEADTIME = DEADTIME_DEF
) (
   input logic             clk,
   input logic             rst_n,
   ac_motor_svpwm_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   dir_e                dir, dir_nxt;
   logic [WIDTH-1:0]    carrier, carrier_nxt;
   logic                peak, to_valley, calc_vld, valley;
   logic [SECTOR_W-1:0] sec_s;
   logic [WIDTH-1:0]    t1_s, t2_s;
   logic [WIDTH:0]      sum;
   logic                sat;
   logic [WIDTH-1:0]    t2_e, t0, hh, d_all, d_t1, d_t2;
   ac_motor_duty_t      duty_calc, duty_sh, duty_act;
   logic [2:0]          cmd, gate_h, gate_l;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir     <= DIR_UP;
         carrier <= '0;
      end else begin
         dir     <= dir_nxt;
         carrier <= carrier_nxt;
      end
   end

   // 0..MAX then MAX-1..1: the valley value 0 and the peak appear once per period
   always_comb begin
      dir_nxt     = dir;
      carrier_nxt = carrier + ONE;
      if (dir == DIR_UP) begin
         if (carrier == MAX) begin
            dir_nxt     = DIR_DN;
            carrier_nxt = carrier - ONE;
         end
      end else begin
         carrier_nxt = carrier - ONE;
         if (carrier == ONE)
            dir_nxt = DIR_UP;
      end
   end

   assign peak      = (dir == DIR_UP) && (carrier == MAX);
   assign to_valley = (dir == DIR_DN) && (carrier == ONE);

   // Over-modulation clips T2 so the active vectors exactly fill the half period
   assign sum   = {1'b0, t1_s} + {1'b0, t2_s};
   assign sat   = sum > {1'b0, MAX};
   assign t2_e  = sat ? (MAX - t1_s) : t2_s;
   assign t0    = sat ? '0 : (MAX - sum[WIDTH-1:0]);
   assign hh    = t0 >> 1;
   assign d_t1  = t1_s + hh;
   assign d_t2  = t2_e + hh;
   assign d_all = t1_s + t2_e + hh;

   always_comb begin
      duty_calc = '0;
      case (sec_s)
         SEC_0: duty_calc = '{u: DUTY_W'(d_all), v: DUTY_W'(d_t2),  w: DUTY_W'(hh)};
         SEC_1: duty_calc = '{u: DUTY_W'(d_t1),  v: DUTY_W'(d_all), w: DUTY_W'(hh)};
         SEC_2: duty_calc = '{u: DUTY_W'(hh),    v: DUTY_W'(d_all), w: DUTY_W'(d_t2)};
         SEC_3: duty_calc = '{u: DUTY_W'(hh),    v: DUTY_W'(d_t1),  w: DUTY_W'(d_all)};
         SEC_4: duty_calc = '{u: DUTY_W'(d_t2),  v: DUTY_W'(hh),    w: DUTY_W'(d_all)};
         SEC_5: duty_calc = '{u: DUTY_W'(d_all), v: DUTY_W'(hh),    w: DUTY_W'(d_t1)};
         default: duty_calc = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_s    <= SEC_0;
         t1_s     <= '0;
         t2_s     <= '0;
         calc_vld <= 1'b0;
         duty_sh  <= '0;
         duty_act <= '0;
         valley   <= 1'b0;
      end else begin
         if (peak) begin
            sec_s <= bus.sector;
            t1_s  <= bus.sine_pos;
            t2_s  <= bus.sine_neg;
         end
         calc_vld <= peak;
         if (calc_vld)
            duty_sh <= duty_calc;
         // Loaded on the edge into carrier==0 so the new duty already governs the valley cycle
         if (to_valley)
            duty_act <= duty_sh;
         valley <= to_valley;
      end
   end

   assign cmd[0] = DUTY_W'(carrier) < duty_act.u;
   assign cmd[1] = DUTY_W'(carrier) < duty_act.v;
   assign cmd[2] = DUTY_W'(carrier) < duty_act.w;

   for (genvar i = 0; i < 3; i++) begin : g_ph
      ac_motor_deadtime #(
         .DEADTIME (DEADTIME)
      ) u_dt (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (bus.en),
         .cmd   (cmd[i]),
         .h     (gate_h[i]),
         .l     (gate_l[i])
      );
   end

   assign bus.u_h    = gate_h[0];
   assign bus.u_l    = gate_l[0];
   assign bus.v_h    = gate_h[1];
   assign bus.v_l    = gate_l[1];
   assign bus.w_h    = gate_h[2];
   assign bus.w_l    = gate_l[2];
   assign bus.valley = valley;

endmodule

// File: doc/ac_motor_svpwm.md
# ac_motor_svpwm

Space-vector PWM modulator for the AC motor vector drive, directly downstream of the sine/sector generator. Consumes the generator's `sector`, `sine_pos` (T1, first active-vector time) and `sine_neg` (T2, second active-vector time) and generates a centre-aligned up/down carrier. Derives the three phase duties from these and drives complementary high/low gate signals with programmable dead time. Also emits a carrier-valley pulse that upstream blocks may use as an update strobe.

## Interface
- `WIDTH`, 12, width of T1/T2, duties and carrier; carrier max `MAX = 2**WIDTH-1`
- `DEADTIME`, 16, dead-time in clk cycles (1..255)

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  modulator enable; low forces all gate outputs low
- `sector`  in  3  sector 0..5; 6/7 invalid
- `sine_pos`  in  WIDTH  T1 in carrier counts
- `sine_neg`  in  WIDTH  T2 in carrier counts
- `u_h`, `u_l`, `v_h`, `v_l`, `w_h`, `w_l`  out  1 each  gate drives
- `valley`  out  1  one-cycle pulse while carrier == 0

## Operation
- **Carrier:** counter counts 0→MAX, then MAX→1, then repeats from 0. Period is 2·MAX cycles (8190 for WIDTH=12). `dir` flips at MAX and at 0. It runs regardless of `en`.
- **Input sampling:** inputs are sampled into stage-1 registers in the cycle the carrier == MAX.
- **Duty calculation:** duties are computed into shadow registers in the following cycle. Shadow is copied to the active compare registers in the cycle the carrier == 0. Input changes at any other time have no effect until the next peak→valley handoff.
- **Width and saturation:** S = T1+T2 is computed at WIDTH+1 bits. If S > MAX, T2 := MAX−T1 and T0 := 0. Otherwise T0 := MAX−S. Define H = T0>>1, which is floor.
- **Duties (U, V, W) per sector:**
  - 0: T1+T2+H, T2+H, H
  - 1: T1+H, T1+T2+H, H
  - 2: H, T1+T2+H, T2+H
  - 3: H, T1+H, T1+T2+H
  - 4: T2+H, H, T1+T2+H
  - 5: T1+T2+H, H, T1+H
  - 6/7: all duties 0
- **Raw phase command:** `cmd_x = (carrier < duty_x)`. Over one period the command is high for 2·duty−1 cycles when duty > 0, and is never high when duty = 0.
- **Dead time (per phase):**
  - `x_h` asserts only after `cmd_x` has been 1 for DEADTIME consecutive cycles.
  - `x_l` asserts only after `cmd_x` has been 0 for DEADTIME consecutive cycles.
  - Each output deasserts in the first cycle after `cmd_x` leaves its level.
  - `x_h` and `x_l` are never both 1.
- **Enable:**
  - While `en`=0, all six outputs are 0 and dead-time counters are held at 0.
  - After `en` rises, outputs follow the dead-time rule from a zero count. The first `x_l` or `x_h` assertion is therefore ≥ DEADTIME cycles later.
- **Reset (async, any time):** carrier=0 and dir=up. Stage-1, shadow and active duties are all 0. Dead-time counters are 0. All gate outputs are 0. `valley`=1 is allowed only once the carrier is running; it is registered and 0 during reset.

## Timing
- **Gate outputs:** registered. `cmd_x` is formed from registered carrier and duty; `x_h`/`x_l` are registered from the dead-time counters.
- **Valley strobe:** `valley` is high for exactly one cycle per period, aligned with carrier == 0.
- **Input-to-output latency:** an input sampled at peak N affects duties from valley N (MAX cycles later) onward.
- **First period after reset:** the first period after reset uses duty 0, so all `_l` outputs are asserted after DEADTIME cycles when `en`=1.

## Structure
- **Shared package `ac_motor_pkg`:**
  - `SECTOR_W`=3
  - sector constants `SEC_0`..`SEC_5`
  - `ac_motor_duty_t` struct {u, v, w}
  - the default `DEADTIME`
- **Sub-module `ac_motor_deadtime`:**
  - instantiated ×3
  - input `cmd`; outputs `h`, `l`; internal 8-bit counter
  - clk/rst_n/en shared with the parent
- **Top-level:** carrier, sampling, saturation and the sector mux.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → all gates 0 and carrier 0 immediately (async). After release, `valley` first pulses 8190 cycles later.
- **Nominal duties:** `en`=1, sector=0, T1=1000, T2=500 → H=1297. Duties U=2797, V=1797, W=1297. Raw high widths 5593/3593/2593 cycles. `u_h` width = 5593−16 = 5577.
- **Saturation:** sector=2, T1=3000, T2=2000 → T2:=1095, T0=0. Duties U=0, V=4095, W=1095. `u_h` is never asserted.
- **Invalid sector:** sector=7 → all duties 0. `x_h`=0 throughout and `x_l`=1 continuously after DEADTIME.
- **Sampling boundary:** change inputs at carrier=2000 (counting down) → outputs unchanged until the next valley after the following peak. Changing inputs at peak+1 is ignored for that period.
- **Enable / dead time:** drop `en` for 100 cycles, then raise it → all outputs 0 while low. After re-enable, no output asserts for 16 cycles. The bench checks `x_h & x_l`=0 on every cycle.
